alu_sequencer: RTL and testbench

Fetch/issue controller that sits directly upstream of the 8-bit ALU. It holds a small writable program memory and steps through it. For each instruction it drives the ALU's `A`, `B` and `opcode` inputs, waits out the ALU's clocked latency, then captures `ALU_Out` into an 8-bit accumulator. That accumulator feeds the next instruction, so a host can run multi-step arithmetic with one `start` pulse and read the result when `done` fires.

---
 rtl/alu_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Fetch/issue controller placed in front of an 8-bit clocked ALU. It holds a
// small writable program memory and runs it from PC 0 on a start pulse. For
// each instruction it presents A/B/opcode, waits out the ALU latency, then
// captures alu_out into the accumulator. The accumulator is the A operand of
// the next instruction when ASEL is 0.
//
// Instruction word:
//   [15:12] opcode (passed to the ALU unchanged)
//   [11]    HALT
//   [10]    reserved
//   [9]     ASEL: 0 -> A = acc, 1 -> A = imm
//   [8]     reserved
//   [7:0]   imm (always drives B)
//
// Parameters:
//   DEPTH    program memory entries (power of two, >= 2)
//   ALU_LAT  ALU cycles from inputs sampled to alu_out valid (>= 1)
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          run request, honoured only when idle
//   prog_we/addr/data  program write port, honoured only when idle
//   alu_out        ALU result
//   alu_a/alu_b/alu_opcode  ALU operands
//   acc            accumulator (cleared only by reset)
//   pc             address of current/next instruction
//   busy           high whenever not idle
//   done           one-cycle pulse when a HALT is reached

module alu_sequencer #(
   parameter int DEPTH   = 16,
   parameter int ALU_LAT = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     prog_we,
   input  logic [$clog2(DEPTH)-1:0] prog_addr,
   input  logic [15:0]              prog_data,
   input  logic [7:0]               alu_out,
   output logic [7:0]               alu_a,
   output logic [7:0]               alu_b,
   output logic [3:0]               alu_opcode,
   output logic [7:0]               acc,
   output logic [$clog2(DEPTH)-1:0] pc,
   output logic                     busy,
   output logic                     done
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(ALU_LAT + 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t        state;
   logic [15:0]   mem [DEPTH];
   logic [15:0]   ir;
   logic [7:0]    a_q;
   logic [7:0]    b_q;
   logic [3:0]    op_q;
   logic [CW-1:0] cnt;
   logic [7:0]    issue_a;
   logic          unused_ir;

   // Reserved bits are never decoded; HALT is decided straight from the
   // memory word during FETCH, so the IR copy of it is not needed either.
   assign unused_ir = ^{ir[11:10], ir[8]};

   assign issue_a = ir[9] ? ir[7:0] : acc;

   // The operands are presented during ISSUE itself so that the ALU samples
   // them at the ISSUE->WAIT edge; with that alignment the result is valid in
   // the last WAIT cycle for any ALU_LAT. From then on the captured copies
   // hold the ALU inputs steady until the next ISSUE.
   always_comb begin
      alu_a      = a_q;
      alu_b      = b_q;
      alu_opcode = op_q;
      if (state == ISSUE) begin
         alu_a      = issue_a;
         alu_b      = ir[7:0];
         alu_opcode = ir[15:12];
      end
   end

   // Program memory is never cleared; writes land only while idle so a
   // running program cannot be modified under its own feet.
   always_ff @(posedge clk) begin
      if (!reset && prog_we && state == IDLE)
         mem[prog_addr] <= prog_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ir    <= '0;
         acc   <= '0;
         pc    <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  pc    <= '0;
                  busy  <= 1'b1;
                  state <= FETCH;
               end
            end
            FETCH: begin
               ir <= mem[pc];
               if (mem[pc][11]) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               a_q   <= issue_a;
               b_q   <= ir[7:0];
               op_q  <= ir[15:12];
               cnt   <= CW'(ALU_LAT);
               state <= WAIT;
            end
            WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  acc   <= alu_out;
                  pc    <= pc + 1'b1;  // wraps modulo DEPTH
                  state <= FETCH;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (ALU_LAT=1 and ALU_LAT=3) share the
// host-side stimulus, each with its own behavioural ALU. A program-level
// model predicts the accumulator trace, final pc and completion cycle.

module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, prog_we;
   logic [3:0]  prog_addr;
   logic [15:0] prog_data;

   logic [7:0] a1, b1, acc1, ao1;
   logic [3:0] op1, pc1;
   logic       busy1, done1;
   logic [7:0] a3, b3, acc3, ao3;
   logic [3:0] op3, pc3;
   logic       busy3, done3;

   always #5 clk = ~clk;

   alu_sequencer #(.DEPTH(16), .ALU_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
      .prog_addr(prog_addr), .prog_data(prog_data), .alu_out(ao1),
      .alu_a(a1), .alu_b(b1), .alu_opcode(op1), .acc(acc1), .pc(pc1),
      .busy(busy1), .done(done1));

   alu_sequencer #(.DEPTH(16), .ALU_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
      .prog_addr(prog_addr), .prog_data(prog_data), .alu_out(ao3),
      .alu_a(a3), .alu_b(b3), .alu_opcode(op3), .acc(acc3), .pc(pc3),
      .busy(busy3), .done(done3));

   function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return {a[6:0], 1'b0};
         4'd6:    return {1'b0, a[7:1]};
         default: return b;
      endcase
   endfunction

   // Behavioural ALUs: result valid ALU_LAT edges after the inputs are sampled.
   logic [7:0] p1;
   logic [7:0] p3 [3];
   always @(posedge clk) begin
      p1    <= alu_f(op1, a1, b1);
      p3[0] <= alu_f(op3, a3, b3);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign ao1 = p1;
   assign ao3 = p3[2];

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model state
   logic [15:0] mem_m [16];
   logic [7:0]  model_acc;
   logic [7:0]  exp_tr [$];
   int          exp_n;
   logic [3:0]  exp_pc;
   logic [7:0]  exp_acc;
   // Measured results of the last run
   logic [7:0]  m_acc1, m_acc3;
   logic [3:0]  m_pc1, m_pc3;
   int          m_k1, m_k3;

   function automatic void model_run();
      logic [3:0]  mpc = 4'd0;
      logic [7:0]  macc = model_acc;
      logic [15:0] w;
      exp_tr.delete();
      for (int i = 0; i < 64; i++) begin
         w = mem_m[mpc];
         if (w[11]) break;
         macc = alu_f(w[15:12], w[9] ? w[7:0] : macc, w[7:0]);
         exp_tr.push_back(macc);
         mpc = mpc + 4'd1;
      end
      exp_n   = exp_tr.size();
      exp_pc  = mpc;
      exp_acc = macc;
   endfunction

   task automatic check_idle_zero(input string tag);
      check({tag, "_acc1"}, 32'(acc1), 0);   check({tag, "_acc3"}, 32'(acc3), 0);
      check({tag, "_pc1"}, 32'(pc1), 0);     check({tag, "_pc3"}, 32'(pc3), 0);
      check({tag, "_busy1"}, 32'(busy1), 0); check({tag, "_busy3"}, 32'(busy3), 0);
   endtask

   // Load (optionally) and run a program; k counts cycles after the start edge,
   // k=1 being the first FETCH cycle. poke_k injects a write to mem[1] plus a
   // start pulse while the sequencers are busy.
   task automatic run(input int nw, input logic [15:0] w [16], input bit load, input int poke_k);
      int k, nd1, nd3, idx;
      bit seen1, seen3, bad_hold;
      logic [19:0] prev, cur;
      if (load) begin
         for (int i = nw - 1; i >= 1; i--) begin
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = w[i]; mem_m[i] = w[i];
            tick();
         end
         prog_we = 1'b1; prog_addr = 4'd0; prog_data = w[0]; mem_m[0] = w[0];
      end
      start = 1'b1;
      model_run();
      tick();
      prog_we = 1'b0; start = 1'b0;
      k = 1; nd1 = 0; nd3 = 0; seen1 = 0; seen3 = 0; bad_hold = 0;
      m_k1 = 0; m_k3 = 0; prev = '0;
      while (k <= 400) begin
         if (k == 1) begin
            check("busy_rise1", 32'(busy1), 1);
            check("busy_rise3", 32'(busy3), 1);
         end
         idx = (k - 1) / 3;
         if (k > 1 && (k - 1) % 3 == 0 && idx <= exp_n)
            check("acc_trace1", 32'(acc1), 32'(exp_tr[idx-1]));
         idx = (k - 1) / 5;
         if (k > 1 && (k - 1) % 5 == 0 && idx <= exp_n)
            check("acc_trace3", 32'(acc3), 32'(exp_tr[idx-1]));
         cur = {a3, b3, op3};
         if (k > 1 && cur != prev && (k - 2) % 5 != 0) bad_hold = 1;
         prev = cur;
         if (done1) begin
            nd1++;
            if (!seen1) begin
               seen1 = 1; m_k1 = k; m_acc1 = acc1; m_pc1 = pc1;
               check("busy_at_done1", 32'(busy1), 1);
            end
         end
         if (done3) begin
            nd3++;
            if (!seen3) begin
               seen3 = 1; m_k3 = k; m_acc3 = acc3; m_pc3 = pc3;
               check("busy_at_done3", 32'(busy3), 1);
            end
         end
         if (seen1 && k == m_k1 + 1) check("busy_fall1", 32'(busy1), 0);
         if (seen3 && k == m_k3 + 1) check("busy_fall3", 32'(busy3), 0);
         if (k == poke_k) begin
            prog_we = 1'b1; prog_addr = 4'd1; prog_data = 16'h00FF; start = 1'b1;
         end else begin
            prog_we = 1'b0; start = 1'b0;
         end
         if (seen1 && seen3 && k >= m_k3 + 2) break;
         tick();
         k++;
      end
      prog_we = 1'b0; start = 1'b0;
      check("done_seen", 32'(seen1 && seen3), 1);
      check("done_k1", m_k1, exp_n * 3 + 2);
      check("done_k3", m_k3, exp_n * 5 + 2);
      check("pc_done1", 32'(m_pc1), 32'(exp_pc));
      check("pc_done3", 32'(m_pc3), 32'(exp_pc));
      check("acc_done1", 32'(m_acc1), 32'(exp_acc));
      check("acc_done3", 32'(m_acc3), 32'(exp_acc));
      check("done_pulses1", nd1, 1);
      check("done_pulses3", nd3, 1);
      check("alu_hold3", 32'(bad_hold), 0);
      model_acc = exp_acc;
   endtask

   typedef struct {
      int          n;
      logic [15:0] w [4];
      logic [7:0]  acc;
      logic [3:0]  pc;
      int          k1;
      int          k3;
   } vec_t;

   vec_t        tbl [4];
   logic [15:0] wb [16];

   initial begin
      tbl[0].n = 3; tbl[0].w = '{16'h0201, 16'h0003, 16'h0800, 16'h0000};
      tbl[0].acc = 8'h05; tbl[0].pc = 4'd2; tbl[0].k1 = 8;  tbl[0].k3 = 12;
      tbl[1].n = 1; tbl[1].w = '{16'h0800, 16'h0000, 16'h0000, 16'h0000};
      tbl[1].acc = 8'h05; tbl[1].pc = 4'd0; tbl[1].k1 = 2;  tbl[1].k3 = 2;
      tbl[2].n = 4; tbl[2].w = '{16'h0264, 16'h10C9, 16'h0002, 16'h0800};
      tbl[2].acc = 8'h01; tbl[2].pc = 4'd3; tbl[2].k1 = 11; tbl[2].k3 = 17;
      tbl[3].n = 3; tbl[3].w = '{16'h03AB, 16'h25F0, 16'h3D00, 16'h0000};
      tbl[3].acc = 8'h50; tbl[3].pc = 4'd2; tbl[3].k1 = 8;  tbl[3].k3 = 12;

      for (int i = 0; i < 16; i++) mem_m[i] = 16'h0800;
      reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;

      // Reset defaults; start during reset is ignored
      tick();
      start = 1'b1;
      tick();
      check_idle_zero("rst");
      check("rst_alu_a1", 32'(a1), 0);  check("rst_alu_b1", 32'(b1), 0);
      check("rst_op1", 32'(op1), 0);    check("rst_done1", 32'(done1), 0);
      check("rst_alu_a3", 32'(a3), 0);  check("rst_done3", 32'(done3), 0);
      reset = 1'b0; start = 1'b0;
      tick();
      check("rst_start_ign1", 32'(busy1), 0);
      check("rst_start_ign3", 32'(busy3), 0);
      model_acc = 8'h00;

      // Table-driven programs
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 16; i++) wb[i] = 16'h0800;
         for (int i = 0; i < 4; i++) wb[i] = tbl[t].w[i];
         run(tbl[t].n, wb, 1'b1, 0);
         check($sformatf("tbl%0d_acc", t), 32'(m_acc1), 32'(tbl[t].acc));
         check($sformatf("tbl%0d_pc", t), 32'(m_pc1), 32'(tbl[t].pc));
         check($sformatf("tbl%0d_k1", t), m_k1, tbl[t].k1);
         check($sformatf("tbl%0d_k3", t), m_k3, tbl[t].k3);
      end

      // Busy-time write and start are ignored; rerun proves mem[1] intact
      for (int i = 0; i < 16; i++) wb[i] = 16'h0800;
      for (int i = 0; i < 4; i++) wb[i] = tbl[0].w[i];
      run(3, wb, 1'b1, 3);
      run(3, wb, 1'b0, 0);
      check("busy_write_acc", 32'(m_acc1), 5);

      // Mid-run reset during the first WAIT cycle of both instances
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle_zero("midrst");
      model_acc = 8'h00;
      run(3, wb, 1'b0, 0);
      check("midrst_rerun_acc", 32'(m_acc1), 5);

      // Randomized programs against the model
      for (int r = 0; r < 15; r++) begin
         int nw;
         nw = int'($urandom_range(2, 6));
         for (int i = 0; i < 16; i++) wb[i] = 16'h0800;
         for (int i = 0; i < nw - 1; i++) wb[i] = 16'($urandom) & 16'hF7FF;
         wb[nw-1] = 16'($urandom) | 16'h0800;
         run(nw, wb, 1'b1, (r % 3 == 0) ? int'($urandom_range(2, 10)) : 0);
      end

      // PC wrap: 16 x (acc+1), no HALT
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 15; i >= 1; i--) begin
         prog_we = 1'b1; prog_addr = 4'(i); prog_data = 16'h0001;
         tick();
      end
      prog_we = 1'b1; prog_addr = 4'd0; prog_data = 16'h0001; start = 1'b1;
      tick();
      prog_we = 1'b0; start = 1'b0;
      for (int k = 1; k <= 86; k++) begin
         if (k == 52) begin
            check("wrap_pc1", 32'(pc1), 1);
            check("wrap_acc1", 32'(acc1), 17);
         end
         if (k == 86) begin
            check("wrap_pc3", 32'(pc3), 1);
            check("wrap_acc3", 32'(acc3), 17);
            check("wrap_busy3", 32'(busy3), 1);
         end
         if (k < 86) tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle_zero("wrap_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
